// File: rtl/associative_memory_folded.sv
// Purpose: folded Hamming-distance classifier; scores one fused hypervector against valence/arousal prototypes, one fold per cycle.
// Latency: NUM_FOLDS+1 cycles from the accepting edge to dout_valid (11 at defaults); one vector in flight at a time.
// Backpressure: hvin_ready is high only when idle; the result holds on dout_valid/valence/arousal until dout_ready.
module associative_memory_folded #(
    parameter int NUM_FOLDS       = 10,
    parameter int NUM_FOLDS_WIDTH = 4,
    parameter int FOLD_WIDTH      = 200,
    localparam int HV_DIMENSION   = NUM_FOLDS * FOLD_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hvin_valid,
    output logic                    hvin_ready,
    input  logic [HV_DIMENSION-1:0] hvin,
    input  logic [HV_DIMENSION-1:0] prototype_v0,
    input  logic [HV_DIMENSION-1:0] prototype_v1,
    input  logic [HV_DIMENSION-1:0] prototype_a0,
    input  logic [HV_DIMENSION-1:0] prototype_a1,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    valence,
    output logic                    arousal
);

    localparam int DIST_WIDTH = $clog2(HV_DIMENSION + 1);
    localparam int POP_WIDTH  = $clog2(FOLD_WIDTH + 1);
    localparam logic [NUM_FOLDS_WIDTH-1:0] LAST_FOLD = NUM_FOLDS_WIDTH'(NUM_FOLDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_COMPARE,
        S_DONE
    } state_e;

    state_e                      state_q, state_d;
    logic [HV_DIMENSION-1:0]     hv_q, hv_d;
    logic [NUM_FOLDS_WIDTH-1:0]  fold_idx_q, fold_idx_d;
    logic [DIST_WIDTH-1:0]       d_v0_q, d_v0_d;
    logic [DIST_WIDTH-1:0]       d_v1_q, d_v1_d;
    logic [DIST_WIDTH-1:0]       d_a0_q, d_a0_d;
    logic [DIST_WIDTH-1:0]       d_a1_q, d_a1_d;
    logic                        valence_q, valence_d;
    logic                        arousal_q, arousal_d;
    logic                        dout_valid_q, dout_valid_d;

    logic [31:0]                 fold_base;
    logic [FOLD_WIDTH-1:0]       s_hv, s_v0, s_v1, s_a0, s_a1;
    logic [POP_WIDTH-1:0]        pop_v0, pop_v1, pop_a0, pop_a1;

    function automatic logic [POP_WIDTH-1:0] popcount(input logic [FOLD_WIDTH-1:0] v);
        logic [POP_WIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < FOLD_WIDTH; i++) begin
            c = c + POP_WIDTH'(v[i]);
        end
        return c;
    endfunction

    // Select the current fold of the captured HV and of each prototype, and score it.
    // A right shift is used instead of a variable part-select so the fold index width never matters.
    always_comb begin
        fold_base = 32'(fold_idx_q) * 32'(FOLD_WIDTH);
        s_hv      = FOLD_WIDTH'(hv_q >> fold_base);
        s_v0      = FOLD_WIDTH'(prototype_v0 >> fold_base);
        s_v1      = FOLD_WIDTH'(prototype_v1 >> fold_base);
        s_a0      = FOLD_WIDTH'(prototype_a0 >> fold_base);
        s_a1      = FOLD_WIDTH'(prototype_a1 >> fold_base);
        pop_v0    = popcount(s_hv ^ s_v0);
        pop_v1    = popcount(s_hv ^ s_v1);
        pop_a0    = popcount(s_hv ^ s_a0);
        pop_a1    = popcount(s_hv ^ s_a1);
    end

    // Next-state and datapath update: accept, accumulate folds, compare, then hold the result.
    always_comb begin
        state_d      = state_q;
        hv_d         = hv_q;
        fold_idx_d   = fold_idx_q;
        d_v0_d       = d_v0_q;
        d_v1_d       = d_v1_q;
        d_a0_d       = d_a0_q;
        d_a1_d       = d_a1_q;
        valence_d    = valence_q;
        arousal_d    = arousal_q;
        dout_valid_d = dout_valid_q;
        case (state_q)
            S_IDLE: begin
                if (hvin_valid) begin
                    hv_d       = hvin;
                    fold_idx_d = '0;
                    d_v0_d     = '0;
                    d_v1_d     = '0;
                    d_a0_d     = '0;
                    d_a1_d     = '0;
                    state_d    = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                // Distances cannot exceed HV_DIMENSION, so the counters never wrap.
                d_v0_d     = d_v0_q + DIST_WIDTH'(pop_v0);
                d_v1_d     = d_v1_q + DIST_WIDTH'(pop_v1);
                d_a0_d     = d_a0_q + DIST_WIDTH'(pop_a0);
                d_a1_d     = d_a1_q + DIST_WIDTH'(pop_a1);
                fold_idx_d = fold_idx_q + 1'b1;
                if (fold_idx_q == LAST_FOLD) begin
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                // Strict less-than: a tie falls to the low class.
                valence_d    = (d_v1_q < d_v0_q);
                arousal_d    = (d_a1_q < d_a0_q);
                dout_valid_d = 1'b1;
                state_d      = S_DONE;
            end
            S_DONE: begin
                if (dout_ready) begin
                    dout_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d      = S_IDLE;
                dout_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any vector in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            hv_q         <= '0;
            fold_idx_q   <= '0;
            d_v0_q       <= '0;
            d_v1_q       <= '0;
            d_a0_q       <= '0;
            d_a1_q       <= '0;
            valence_q    <= 1'b0;
            arousal_q    <= 1'b0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hv_q         <= hv_d;
            fold_idx_q   <= fold_idx_d;
            d_v0_q       <= d_v0_d;
            d_v1_q       <= d_v1_d;
            d_a0_q       <= d_a0_d;
            d_a1_q       <= d_a1_d;
            valence_q    <= valence_d;
            arousal_q    <= arousal_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign hvin_ready = (state_q == S_IDLE);
    assign dout_valid = dout_valid_q;
    assign valence    = valence_q;
    assign arousal    = arousal_q;

endmodule
